elc3_mem_io_ctrl: RTL and testbench

//  Parametrised memory/IO controller answering the eLC-3 control unit's MIO_EN/R_W memory cycles.

---
 rtl/elc3_pkg.sv | 17 +
 rtl/elc3_io_regs.sv | 50 +++++
 rtl/elc3_mem_io_ctrl.sv | 116 +++++++++++
 tb/tb_elc3_mem_io_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/elc3_pkg.sv
// Shared types and constants for the eLC-3 memory/IO controller.
package elc3_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMem,
    StIo,
    StDone
  } mio_state_t;

  localparam logic [15:0] DefaultIoBase = 16'hFE00;

  // R_W encodings as driven by the control unit
  localparam logic RwRead  = 1'b0;
  localparam logic RwWrite = 1'b1;

endpackage

// File: rtl/elc3_io_regs.sv
// Memory-mapped IO channel bank: output registers, input read mux and access strobes.
module elc3_io_regs #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_IO   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic                     rd_en_i,
  input  logic [ADDR_W-1:0]        sel_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [N_IO*DATA_W-1:0]   io_in_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [N_IO*DATA_W-1:0]   io_out_o,
  output logic [N_IO-1:0]          io_wr_stb_o,
  output logic [N_IO-1:0]          io_rd_stb_o
);

  logic [N_IO-1:0] onehot;

  // Full-width compare: offsets at or beyond N_IO select nothing and read back as zero.
  always_comb begin
    onehot  = '0;
    rdata_o = '0;
    for (int unsigned i = 0; i < N_IO; i++) begin
      if (sel_i == ADDR_W'(i)) begin
        onehot[i] = 1'b1;
        rdata_o   = io_in_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      io_out_o    <= '0;
      io_wr_stb_o <= '0;
      io_rd_stb_o <= '0;
    end else begin
      io_wr_stb_o <= onehot & {N_IO{wr_en_i}};
      io_rd_stb_o <= onehot & {N_IO{rd_en_i}};
      for (int unsigned i = 0; i < N_IO; i++) begin
        if (wr_en_i && onehot[i]) begin
          io_out_o[i*DATA_W +: DATA_W] <= wdata_i;
        end
      end
    end
  end

endmodule

// File: rtl/elc3_mem_io_ctrl.sv
// Memory/IO controller for the eLC-3: decodes each MIO_EN cycle to wait-stated RAM or an IO
// channel and ends every accepted request with a one-cycle R pulse.
module elc3_mem_io_ctrl
  import elc3_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       N_IO     = 4,
  parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(DefaultIoBase),
  parameter int unsigned       MEM_WAIT = 2
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   MIO_EN,
  input  logic                   R_W,
  input  logic [ADDR_W-1:0]      Addr,
  input  logic [DATA_W-1:0]      WrData,
  output logic [DATA_W-1:0]      RdData,
  output logic                   R,
  output logic                   mem_ce,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic [N_IO*DATA_W-1:0] io_in,
  output logic [N_IO*DATA_W-1:0] io_out,
  output logic [N_IO-1:0]        io_wr_stb,
  output logic [N_IO-1:0]        io_rd_stb
);

  localparam int unsigned CntW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  mio_state_t        state_q;
  logic [CntW-1:0]   cnt_q;
  logic              rw_q;
  logic [ADDR_W-1:0] io_sel;
  logic [DATA_W-1:0] io_rdata;
  logic              io_wr_en;
  logic              io_rd_en;

  // Only reached from an address at or above IO_BASE, so the offset never wraps.
  assign io_sel   = mem_addr - IO_BASE;
  assign io_wr_en = (state_q == StIo) && (rw_q == RwWrite);
  assign io_rd_en = (state_q == StIo) && (rw_q == RwRead);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rw_q      <= RwRead;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      R         <= 1'b0;
      RdData    <= '0;
    end else begin
      R <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (MIO_EN) begin
            rw_q      <= R_W;
            mem_addr  <= Addr;
            mem_wdata <= WrData;
            if (Addr < IO_BASE) begin
              state_q <= StMem;
              cnt_q   <= CntW'(MEM_WAIT);
              mem_ce  <= 1'b1;
              mem_we  <= R_W;
            end else begin
              state_q <= StIo;
            end
          end
        end
        StMem: begin
          if (cnt_q == '0) begin
            // RAM data is sampled on the last edge of the access, while mem_ce is still high
            if (rw_q == RwRead) RdData <= mem_rdata;
            mem_ce  <= 1'b0;
            mem_we  <= 1'b0;
            R       <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StIo: begin
          if (rw_q == RwRead) RdData <= io_rdata;
          R       <= 1'b1;
          state_q <= StDone;
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  elc3_io_regs #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .N_IO   (N_IO)
  ) u_io_regs (
    .clk_i       (Clk),
    .rst_ni      (Reset_n),
    .wr_en_i     (io_wr_en),
    .rd_en_i     (io_rd_en),
    .sel_i       (io_sel),
    .wdata_i     (mem_wdata),
    .io_in_i     (io_in),
    .rdata_o     (io_rdata),
    .io_out_o    (io_out),
    .io_wr_stb_o (io_wr_stb),
    .io_rd_stb_o (io_rd_stb)
  );

endmodule

// File: tb/tb_elc3_mem_io_ctrl.sv
// Directed bench: two controller instances (MEM_WAIT=2 and MEM_WAIT=0) share one stimulus bus.
module tb_elc3_mem_io_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mio_en;
  logic        r_w;
  logic [15:0] addr;
  logic [15:0] wr_data;
  logic [15:0] mem_rdata;
  logic [63:0] io_in;

  logic [15:0] rd2, rd0, maddr2, maddr0, mwd2, mwd0;
  logic        r2, r0, ce2, ce0, we2, we0;
  logic [63:0] ioo2, ioo0;
  logic [3:0]  iws2, iws0, irs2, irs0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  elc3_mem_io_ctrl #(.MEM_WAIT(2)) dut2 (
    .Clk(clk), .Reset_n(reset_n), .MIO_EN(mio_en), .R_W(r_w), .Addr(addr), .WrData(wr_data),
    .RdData(rd2), .R(r2), .mem_ce(ce2), .mem_we(we2), .mem_addr(maddr2), .mem_wdata(mwd2),
    .mem_rdata(mem_rdata), .io_in(io_in), .io_out(ioo2), .io_wr_stb(iws2), .io_rd_stb(irs2)
  );

  elc3_mem_io_ctrl #(.MEM_WAIT(0)) dut0 (
    .Clk(clk), .Reset_n(reset_n), .MIO_EN(mio_en), .R_W(r_w), .Addr(addr), .WrData(wr_data),
    .RdData(rd0), .R(r0), .mem_ce(ce0), .mem_we(we0), .mem_addr(maddr0), .mem_wdata(mwd0),
    .mem_rdata(mem_rdata), .io_in(io_in), .io_out(ioo0), .io_wr_stb(iws0), .io_rd_stb(irs0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Presents a request for one edge; returns just after the accepting edge.
  task automatic req(input logic rw, input logic [15:0] a, input logic [15:0] d);
    mio_en  = 1'b1;
    r_w     = rw;
    addr    = a;
    wr_data = d;
    tick();
    mio_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Samples n cycles starting at the accept point; index 0 is the cycle after accept.
  task automatic observe(input bit fast, input int n, output int ce_n, output int we_n,
                         output int r_at, output int r_n, output int wstb_n, output int rstb_n,
                         output logic [3:0] wstb_or, output logic [3:0] rstb_or);
    ce_n = 0; we_n = 0; r_at = -1; r_n = 0; wstb_n = 0; rstb_n = 0;
    wstb_or = '0; rstb_or = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      if (fast ? ce0 : ce2) ce_n++;
      if (fast ? we0 : we2) we_n++;
      if (fast ? r0 : r2) begin
        if (r_at < 0) r_at = i;
        r_n++;
      end
      if ((fast ? iws0 : iws2) != 0) wstb_n++;
      if ((fast ? irs0 : irs2) != 0) rstb_n++;
      wstb_or |= fast ? iws0 : iws2;
      rstb_or |= fast ? irs0 : irs2;
    end
  endtask

  initial begin
    int ce_n, we_n, r_at, r_n, wstb_n, rstb_n, r_first, r_second;
    logic [3:0]  wstb_or, rstb_or;
    logic [15:0] rd_first;

    reset_n = 1'b0; mio_en = 1'b0; r_w = 1'b0; addr = '0; wr_data = '0;
    mem_rdata = '0; io_in = '0;
    idle(3);
    chk("rst_r", {63'd0, r2}, 64'd0);
    chk("rst_ce", {63'd0, ce2}, 64'd0);
    chk("rst_rd", {48'd0, rd2}, 64'd0);
    chk("rst_maddr", {48'd0, maddr2}, 64'd0);
    chk("rst_io_out", ioo2, 64'd0);
    chk("rst_stb", {56'd0, iws2, irs2}, 64'd0);
    reset_n = 1'b1;
    idle(2);

    // RAM read, 2 wait states; address change after accept must not matter
    mem_rdata = 16'hBEEF;
    req(1'b0, 16'h3000, 16'h0000);
    addr = 16'h1111;
    observe(1'b0, 7, ce_n, we_n, r_at, r_n, wstb_n, rstb_n, wstb_or, rstb_or);
    chk("ram_rd_ce_cycles", 64'(ce_n), 64'd3);
    chk("ram_rd_we_cycles", 64'(we_n), 64'd0);
    chk("ram_rd_r_at", 64'(r_at), 64'd3);
    chk("ram_rd_r_pulses", 64'(r_n), 64'd1);
    chk("ram_rd_data", {48'd0, rd2}, 64'h0000_0000_0000_BEEF);
    chk("ram_rd_maddr", {48'd0, maddr2}, 64'h3000);
    chk("ram_rd_no_stb", {56'd0, wstb_or, rstb_or}, 64'd0);
    idle(4);

    // IO write, channel 1
    req(1'b1, 16'hFE01, 16'h00A5);
    observe(1'b0, 5, ce_n, we_n, r_at, r_n, wstb_n, rstb_n, wstb_or, rstb_or);
    chk("io_wr_ce_cycles", 64'(ce_n), 64'd0);
    chk("io_wr_r_at", 64'(r_at), 64'd1);
    chk("io_wr_stb_cycles", 64'(wstb_n), 64'd1);
    chk("io_wr_stb", {60'd0, wstb_or}, 64'b0010);
    chk("io_wr_rd_stb", {60'd0, rstb_or}, 64'd0);
    chk("io_wr_out", ioo2, 64'h0000_0000_00A5_0000);
    chk("io_wr_rd_kept", {48'd0, rd2}, 64'hBEEF);
    idle(3);

    // IO read of an unmapped channel
    io_in = 64'h0000_1234_0000_0000;
    req(1'b0, 16'hFE07, 16'h0000);
    observe(1'b0, 5, ce_n, we_n, r_at, r_n, wstb_n, rstb_n, wstb_or, rstb_or);
    chk("io_unmap_r_at", 64'(r_at), 64'd1);
    chk("io_unmap_rd", {48'd0, rd2}, 64'd0);
    chk("io_unmap_no_stb", {56'd0, wstb_or, rstb_or}, 64'd0);
    chk("io_unmap_out_kept", ioo2, 64'h0000_0000_00A5_0000);
    idle(3);

    // IO read, channel 2
    req(1'b0, 16'hFE02, 16'h0000);
    observe(1'b0, 5, ce_n, we_n, r_at, r_n, wstb_n, rstb_n, wstb_or, rstb_or);
    chk("io_rd_r_at", 64'(r_at), 64'd1);
    chk("io_rd_data", {48'd0, rd2}, 64'h1234);
    chk("io_rd_stb", {60'd0, rstb_or}, 64'b0100);
    chk("io_rd_stb_cycles", 64'(rstb_n), 64'd1);
    chk("io_rd_wr_stb", {60'd0, wstb_or}, 64'd0);
    idle(3);

    // Reset in the middle of a RAM write
    req(1'b1, 16'h2000, 16'h5555);
    tick();
    chk("mid_ce_before", {63'd0, ce2}, 64'd1);
    chk("mid_we_before", {63'd0, we2}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_ce_async", {63'd0, ce2}, 64'd0);
    chk("mid_we_async", {63'd0, we2}, 64'd0);
    chk("mid_io_out", ioo2, 64'd0);
    idle(2);
    reset_n = 1'b1;
    observe(1'b0, 6, ce_n, we_n, r_at, r_n, wstb_n, rstb_n, wstb_or, rstb_or);
    chk("mid_no_r", 64'(r_n), 64'd0);
    chk("mid_no_ce", 64'(ce_n), 64'd0);
    chk("mid_rd", {48'd0, rd2}, 64'd0);
    idle(2);

    // Back-to-back RAM reads with MIO_EN held, no wait states
    mem_rdata = 16'h1111;
    mio_en = 1'b1; r_w = 1'b0; addr = 16'h0100;
    tick();
    r_first = -1; r_second = -1; r_n = 0; rd_first = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      if (r0) begin
        r_n++;
        if (r_first < 0) begin
          r_first  = i;
          rd_first = rd0;
        end else if (r_second < 0) begin
          r_second = i;
        end
      end
      if (i == 1) addr = 16'h0300;
      if (i == 2) begin
        addr      = 16'h0200;
        mem_rdata = 16'h2222;
      end
      if (i == 4) mio_en = 1'b0;
    end
    chk("b2b_r_first", 64'(r_first), 64'd1);
    chk("b2b_r_second", 64'(r_second), 64'd4);
    chk("b2b_r_pulses", 64'(r_n), 64'd2);
    chk("b2b_rd_first", {48'd0, rd_first}, 64'h1111);
    chk("b2b_rd_second", {48'd0, rd0}, 64'h2222);
    chk("b2b_maddr", {48'd0, maddr0}, 64'h0200);
    idle(4);

    // Zero-wait RAM write leaves RdData alone
    req(1'b1, 16'h0000, 16'hFFFF);
    observe(1'b1, 5, ce_n, we_n, r_at, r_n, wstb_n, rstb_n, wstb_or, rstb_or);
    chk("w0_ce_cycles", 64'(ce_n), 64'd1);
    chk("w0_we_cycles", 64'(we_n), 64'd1);
    chk("w0_r_at", 64'(r_at), 64'd1);
    chk("w0_rd_kept", {48'd0, rd0}, 64'h2222);
    chk("w0_wdata", {48'd0, mwd0}, 64'hFFFF);
    chk("w0_maddr", {48'd0, maddr0}, 64'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
